// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake bundle for the unified-memory arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;
    logic                  if_stall;
    logic                  d_req;
    logic                  d_we;
    logic [1:0]            d_size;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_valid;
    logic                  d_err;
    logic                  d_stall;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_err, d_stall,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_err, d_stall,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data stages,
// data first, with a run counter that forces a fetch grant after MAX_DATA_RUN data grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} arbState;

    arbState state, nextState;
    logic [3:0] runCnt;
    logic ownerD, errFlag, flushed;
    logic [1:0] lane, sizeReg;
    logic aligned, dErr, dGrant, ifGrant, ifDone, dDone;
    logic [3:0] dBe;
    logic [DATA_WIDTH-1:0] dWdata, shifted, loadData;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        aligned = bus.d_size == 2'b00 || (bus.d_size == 2'b01 && !bus.d_addr[0]) ||
                  (bus.d_size[1] && bus.d_addr[1:0] == 2'b00);
        dErr = bus.d_req && !aligned;
        dGrant = bus.d_req && aligned && (!bus.if_req || runCnt < 4'(MAX_DATA_RUN));
        ifGrant = !dErr && !dGrant && bus.if_req && !bus.if_flush;
        nextState = state == IDLE ? (dErr ? RESP : dGrant ? BUSY_D : ifGrant ? BUSY_IF : IDLE)
                  : state == RESP ? IDLE
                  : bus.mem_ack ? RESP : state;
    end

    always_comb begin
        ifDone = state == RESP && !ownerD && !flushed && !bus.if_flush;
        dDone = state == RESP && ownerD && !errFlag;
        bus.mem_req = state == BUSY_IF || state == BUSY_D;
        bus.if_valid = ifDone;
        bus.d_valid = dDone;
        bus.d_err = state == RESP && errFlag;
        bus.if_stall = bus.if_req && !ifDone;
        bus.d_stall = bus.d_req && !(dDone || (state == RESP && errFlag));
    end

    // Store lanes are replicated so the memory only needs the byte enables to place them.
    always_comb begin
        dBe = bus.d_size == 2'b00 ? 4'b0001 << bus.d_addr[1:0]
            : bus.d_size == 2'b01 ? 4'b0011 << bus.d_addr[1:0] : 4'b1111;
        dWdata = bus.d_size == 2'b00 ? {4{bus.d_wdata[7:0]}}
               : bus.d_size == 2'b01 ? {2{bus.d_wdata[15:0]}} : bus.d_wdata;
        shifted = bus.mem_rdata >> {lane, 3'b000};
        loadData = sizeReg == 2'b00 ? DATA_WIDTH'(shifted[7:0])
                 : sizeReg == 2'b01 ? DATA_WIDTH'(shifted[15:0]) : shifted;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            runCnt <= '0;
            ownerD <= 1'b0;
            errFlag <= 1'b0;
            flushed <= 1'b0;
            lane <= '0;
            sizeReg <= '0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_be <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata <= '0;
            bus.d_rdata <= '0;
        end else begin
            if (state == IDLE && (dErr || dGrant || ifGrant)) begin
                ownerD <= !ifGrant;
                errFlag <= dErr;
                flushed <= 1'b0;
                lane <= bus.d_addr[1:0];
                sizeReg <= bus.d_size;
            end else begin
                flushed <= flushed || bus.if_flush;
            end
            if (state == IDLE && dGrant) begin
                runCnt <= bus.if_req ? runCnt + 4'd1 : 4'd0;
                bus.mem_we <= bus.d_we;
                bus.mem_addr <= bus.d_addr & ~ADDR_WIDTH'(3);
                bus.mem_be <= dBe;
                bus.mem_wdata <= dWdata;
            end else if (state == IDLE && ifGrant) begin
                runCnt <= '0;
                bus.mem_we <= 1'b0;
                bus.mem_addr <= bus.if_addr & ~ADDR_WIDTH'(3);
                bus.mem_be <= 4'b1111;
            end
            if (state == BUSY_IF && bus.mem_ack) bus.if_rdata <= bus.mem_rdata;
            if (state == BUSY_D && bus.mem_ack) bus.d_rdata <= bus.mem_we ? '0 : loadData;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized fetch/data traffic against a byte-level memory model,
// with a queue scoreboard checked by a monitor whenever a completion pulse appears.
module tb_mem_port_arbiter;
    localparam int MAXRUN = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_RUN(MAXRUN)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {bit isErr; logic [31:0] data;} dExpT;

    int vecs = 0, errs = 0, cyc = 0;
    logic [7:0] refBytes [1024];
    logic [31:0] memWords [256];
    int ackDelay = 0, waitCnt = 0, reqCycles = 0, ifValidCyc = 0, dDoneCyc = 0;
    bit respEn = 1'b1, randDelay = 1'b0, ifGot = 1'b0, dGot = 1'b0;
    logic [31:0] lastAddr, lastWdata;
    logic [3:0] lastBe;
    logic lastWe;
    logic [31:0] fQ [$];
    dExpT dQ [$];
    int grantLog [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        vecs++;
        errs++;
        $display("FAIL %s", name);
    endfunction

    function automatic void setWord(input logic [31:0] a, input logic [31:0] v);
        memWords[a[9:2]] = v;
        for (int i = 0; i < 4; i++) refBytes[int'(a[9:2]) * 4 + i] = v[8*i +: 8];
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] a);
        int b = int'(a[9:2]) * 4;
        return {refBytes[b+3], refBytes[b+2], refBytes[b+1], refBytes[b]};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doFetch(input logic [31:0] addr, input int flushAt);
        int n = 0;
        fQ.push_back(refWord(addr));
        ifGot = 1'b0;
        bus.if_addr = addr;
        bus.if_req = 1'b1;
        while (1) begin
            idle(1);
            n++;
            if (ifGot) begin
                ifGot = 1'b0;
                bus.if_req = 1'b0;
                break;
            end
            if (n == flushAt) begin
                bus.if_req = 1'b0;
                bus.if_flush = 1'b1;
                void'(fQ.pop_back());
                idle(1);
                bus.if_flush = 1'b0;
                break;
            end
            if (n > 100) begin
                fail("fetch_timeout");
                bus.if_req = 1'b0;
                void'(fQ.pop_back());
                break;
            end
        end
    endtask

    task automatic doData(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        dExpT e;
        int n = 0;
        int nb = size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
        e.isErr = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
        e.data = '0;
        if (!e.isErr)
            for (int i = 0; i < nb; i++)
                if (we) refBytes[int'(addr[9:0]) + i] = wdata[8*i +: 8];
                else e.data[8*i +: 8] = refBytes[int'(addr[9:0]) + i];
        dQ.push_back(e);
        dGot = 1'b0;
        bus.d_we = we;
        bus.d_size = size;
        bus.d_addr = addr;
        bus.d_wdata = wdata;
        bus.d_req = 1'b1;
        while (1) begin
            idle(1);
            n++;
            if (dGot) begin
                dGot = 1'b0;
                bus.d_req = 1'b0;
                break;
            end
            if (n > 100) begin
                fail("data_timeout");
                bus.d_req = 1'b0;
                void'(dQ.pop_back());
                break;
            end
        end
    endtask

    task automatic checkResetVals(input string p);
        check({p, "mem_req"}, bus.mem_req, 0);
        check({p, "mem_we"}, bus.mem_we, 0);
        check({p, "mem_be"}, bus.mem_be, 0);
        check({p, "mem_addr"}, bus.mem_addr, 0);
        check({p, "mem_wdata"}, bus.mem_wdata, 0);
        check({p, "if_valid"}, bus.if_valid, 0);
        check({p, "d_valid"}, bus.d_valid, 0);
        check({p, "d_err"}, bus.d_err, 0);
        check({p, "if_rdata"}, bus.if_rdata, 0);
        check({p, "d_rdata"}, bus.d_rdata, 0);
    endtask

    // Memory model: acks after ackDelay cycles of mem_req and applies stores by byte enable.
    initial begin
        int idx;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            idle(1);
            if (!respEn) continue;
            if (bus.mem_req && !reset) begin
                if (waitCnt == ackDelay) begin
                    idx = int'(bus.mem_addr[9:2]);
                    check("mem_addr_range", {bus.mem_addr[31:10], bus.mem_addr[1:0]}, 0);
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = memWords[idx];
                    if (bus.mem_we)
                        for (int l = 0; l < 4; l++)
                            if (bus.mem_be[l]) memWords[idx][8*l +: 8] = bus.mem_wdata[8*l +: 8];
                    lastAddr = bus.mem_addr;
                    lastBe = bus.mem_be;
                    lastWe = bus.mem_we;
                    lastWdata = bus.mem_wdata;
                    waitCnt = 0;
                    if (randDelay) ackDelay = $urandom_range(0, 3);
                end else begin
                    bus.mem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                waitCnt = 0;
            end
        end
    end

    initial begin
        dExpT e;
        forever begin
            @(negedge clk);
            if (bus.mem_req) reqCycles++;
            check("if_stall", bus.if_stall, bus.if_req & ~bus.if_valid);
            check("d_stall", bus.d_stall, bus.d_req & ~(bus.d_valid | bus.d_err));
            if (bus.if_valid) begin
                grantLog.push_back(1);
                ifValidCyc = cyc;
                ifGot = 1'b1;
                if (fQ.size() == 0) fail("if_valid_unexpected");
                else check("if_rdata", bus.if_rdata, fQ.pop_front());
            end
            if (bus.d_valid || bus.d_err) begin
                if (bus.d_valid) grantLog.push_back(0);
                dDoneCyc = cyc;
                dGot = 1'b1;
                if (dQ.size() == 0) fail("d_resp_unexpected");
                else begin
                    e = dQ.pop_front();
                    check("d_err", bus.d_err, e.isErr);
                    check("d_valid", bus.d_valid, !e.isErr);
                    if (!e.isErr) check("d_rdata", bus.d_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
        for (int w = 0; w < 256; w++) setWord(w * 4, $urandom);
        repeat (3) @(negedge clk);
        checkResetVals("reset_");
        idle(1);
        reset = 1'b0;

        setWord(32'h100, 32'h00500093);
        t = cyc;
        doFetch(32'h100, -1);
        check("fetch_latency", ifValidCyc - t, 2);
        check("fetch_be", lastBe, 4'b1111);
        check("fetch_we", lastWe, 0);
        check("fetch_addr", lastAddr, 32'h100);

        setWord(32'h200, 32'hAB000000);
        doData(1'b0, 2'b00, 32'h203, 0);
        check("lb_addr", lastAddr, 32'h200);
        check("lb_be", lastBe, 4'b1000);
        doData(1'b1, 2'b01, 32'h202, 32'h1234BEEF);
        check("sh_be", lastBe, 4'b1100);
        check("sh_wdata", lastWdata, 32'hBEEFBEEF);
        check("sh_we", lastWe, 1);
        doData(1'b0, 2'b10, 32'h200, 0);

        grantLog.delete();
        fork
            repeat (8) doData(1'b0, 2'b10, 32'h300, 0);
            repeat (2) doFetch(32'h40, -1);
        join
        check("grant_count", grantLog.size(), 10);
        for (int k = 0; k < 10; k++)
            check($sformatf("grant_order_%0d", k), k < grantLog.size() ? grantLog[k] : -1,
                  (k % (MAXRUN + 1) == MAXRUN) ? 1 : 0);

        reqCycles = 0;
        t = cyc;
        doData(1'b0, 2'b10, 32'h1002, 0);
        check("err_latency", dDoneCyc - t, 1);
        check("err_no_mem_req", reqCycles, 0);
        t = cyc;
        doFetch(32'h44, -1);
        check("after_err_latency", ifValidCyc - t, 2);

        ackDelay = 3;
        reqCycles = 0;
        t = cyc;
        doFetch(32'h80, 2);
        doFetch(32'h84, -1);
        check("flush_refetch_cyc", ifValidCyc - t, 11);
        check("flush_req_cycles", reqCycles, 8);

        ackDelay = 10;
        bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h104; bus.d_req = 1'b1;
        idle(2);
        check("busy_d_mem_req", bus.mem_req, 1);
        #2;
        reset = 1'b1;
        bus.d_req = 1'b0;
        #1;
        checkResetVals("midreset_");
        idle(1);
        reset = 1'b0;
        respEn = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        idle(1);
        bus.mem_ack = 1'b0;
        waitCnt = 0;
        ackDelay = 0;
        respEn = 1'b1;
        idle(3);
        check("stray_ack_mem_req", bus.mem_req, 0);
        t = cyc;
        doFetch(32'h48, -1);
        check("post_reset_latency", ifValidCyc - t, 2);

        randDelay = 1'b1;
        fork
            for (int i = 0; i < 60; i++) begin
                doFetch(32'($urandom_range(0, 63)) * 4,
                        $urandom_range(0, 5) == 0 ? int'($urandom_range(1, 6)) : -1);
                idle($urandom_range(0, 2));
            end
            for (int i = 0; i < 80; i++) begin
                logic [1:0] sz;
                logic [31:0] a;
                sz = 2'($urandom_range(0, 3));
                a = 32'h100 + 32'($urandom_range(0, 32'h2FF));
                if ($urandom_range(0, 3) != 0) a = sz == 2'b00 ? a : sz == 2'b01 ? a & ~32'd1 : a & ~32'd3;
                doData(1'($urandom_range(0, 1)), sz, a, $urandom);
                idle($urandom_range(0, 2));
            end
        join
        idle(5);
        check("fetch_queue_empty", fQ.size(), 0);
        check("data_queue_empty", dQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
